// File: rtl/sprite_pkg.sv
// Shared sprite geometry and loader FSM state encoding.
// Also used by the display-side address generator.
package sprite_pkg;

    localparam int DIM_LOG2_DEF = 6;
    localparam int ADDR_W_DEF   = 2 * DIM_LOG2_DEF;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_BLANK,
        LOAD,
        DONE
    } state_t;

endpackage

// File: rtl/sprite_raster_counter.sv
// Raster-order col/row counter for one sprite.
// The last flag marks the final pixel of the sprite.
module sprite_raster_counter #(
    parameter int DIM_LOG2 = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic                inc,
    output logic [DIM_LOG2-1:0] row,
    output logic [DIM_LOG2-1:0] col,
    output logic                last
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row <= '0;
            col <= '0;
        end else if (clr) begin
            row <= '0;
            col <= '0;
        end else if (inc) begin
            col <= col + 1'b1;
            if (&col) begin
                row <= row + 1'b1;
            end
        end
    end

    assign last = (&row) & (&col);

endmodule

// File: rtl/sprite_loader.sv
// Streams one raster-ordered sprite into sprite memory,
// writing only while the display is in vertical blanking.
module sprite_loader
    import sprite_pkg::*;
#(
    parameter int PIXEL_W  = 8,
    parameter int DIM_LOG2 = DIM_LOG2_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  frame_blank,
    input  logic [PIXEL_W-1:0]    pix_data,
    input  logic                  pix_valid,
    output logic                  pix_ready,
    output logic                  we,
    output logic [2*DIM_LOG2-1:0] waddr,
    output logic [PIXEL_W-1:0]    wdata,
    output logic                  busy,
    output logic                  done
);

    state_t state;
    state_t state_next;

    logic [DIM_LOG2-1:0] row;
    logic [DIM_LOG2-1:0] col;
    logic                last;
    logic                xfer;
    logic                cnt_clr;

    assign xfer    = pix_valid & pix_ready;
    assign cnt_clr = (state == IDLE);

    sprite_raster_counter #(
        .DIM_LOG2(DIM_LOG2)
    ) u_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (cnt_clr),
        .inc  (xfer),
        .row  (row),
        .col  (col),
        .last (last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (start && !abort) begin
                    state_next = WAIT_BLANK;
                end
            end
            WAIT_BLANK: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (frame_blank) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (xfer && last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Abort gates ready so a pixel offered in the abort cycle is never taken.
    always_comb begin
        pix_ready = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
            end
            WAIT_BLANK: begin
            end
            LOAD: begin
                pix_ready = frame_blank & ~abort;
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we    <= 1'b0;
            waddr <= '0;
            wdata <= '0;
        end else begin
            we <= xfer;
            if (xfer) begin
                waddr <= {row, col};
                wdata <= pix_data;
            end
        end
    end

endmodule

// File: tb/tb_sprite_loader.sv
// Randomized scoreboard bench for sprite_loader.
// Expected writes are queued by the driver and popped by the monitor.
module tb_sprite_loader;

    localparam int NPIX = 4096;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic        frame_blank;
    logic [7:0]  pix_data;
    logic        pix_valid;
    logic        pix_ready;
    logic        we;
    logic [11:0] waddr;
    logic [7:0]  wdata;
    logic        busy;
    logic        done;

    typedef struct {
        int         addr;
        logic [7:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_done  = 0;

    sprite_loader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .frame_blank(frame_blank),
        .pix_data   (pix_data),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .we         (we),
        .waddr      (waddr),
        .wdata      (wdata),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act,
                       input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every write must match the next expected pixel in order.
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n) begin
            if (we) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", waddr, -1);
                end else begin
                    e = exp_q.pop_front();
                    chk("waddr", waddr, e.addr);
                    chk("wdata", wdata, e.data);
                    chk("done_with_last", done, e.addr == NPIX - 1);
                end
            end else if (done) begin
                chk("stray_done", done, 0);
            end
            if (done) n_done++;
        end
    end

    task automatic realign();
        @(posedge clk);
        #1;
    endtask

    task automatic run_load(input int vpct, input bit idx,
                            input int wait_n, input int pause_at,
                            input int abort_at, input int rst_at,
                            input bit start_noise);
        int k = 0;
        int waited = 0;
        int gap = 0;
        int budget = 0;
        bit fin = 0;
        logic [7:0] cur;
        cur = idx ? 8'd0 : 8'($urandom);
        start = 1'b1;
        realign();
        start = 1'b0;
        while (!fin) begin
            frame_blank = 1'b1;
            if (waited < wait_n) begin
                frame_blank = 1'b0;
                waited++;
            end else if (k == pause_at && gap < 20) begin
                frame_blank = 1'b0;
                gap++;
            end
            pix_valid = ($urandom_range(99) < vpct);
            pix_data  = cur;
            abort     = (k == abort_at);
            if (abort) pix_valid = 1'b1;
            start = start_noise && k > 10 && k < 4000 &&
                    ($urandom_range(7) == 0);
            @(negedge clk);
            if (!frame_blank) begin
                chk("gap_ready", pix_ready, 0);
                chk("gap_busy", busy, 1);
            end
            if (abort) chk("abort_ready", pix_ready, 0);
            if (pix_valid && pix_ready) begin
                exp_q.push_back('{k, cur});
                k++;
                cur = idx ? 8'(k) : 8'($urandom);
            end
            if (k == rst_at) begin
                #2 rst_n = 1'b0;
                #1;
                chk("rst_we", we, 0);
                chk("rst_waddr", waddr, 0);
                chk("rst_wdata", wdata, 0);
                chk("rst_busy", busy, 0);
                chk("rst_done", done, 0);
                chk("rst_ready", pix_ready, 0);
                exp_q.delete();
                pix_valid = 1'b0;
                start = 1'b0;
                repeat (3) @(negedge clk);
                rst_n = 1'b1;
                fin = 1;
            end else begin
                realign();
                if (abort) begin
                    abort = 1'b0;
                    chk("abort_busy", busy, 0);
                    fin = 1;
                end else if (k == NPIX) begin
                    fin = 1;
                end
                budget++;
                if (budget > 20000) begin
                    chk("timeout", k, NPIX);
                    fin = 1;
                end
            end
        end
        start = 1'b0;
        pix_valid = 1'b0;
    endtask

    task automatic finish_full(input string name, input int d0,
                               input bit abort_in_done);
        abort = abort_in_done;
        realign();
        abort = 1'b0;
        repeat (3) realign();
        chk({name, "_done_cnt"}, n_done - d0, 1);
        chk({name, "_q_empty"}, exp_q.size(), 0);
        chk({name, "_idle"}, busy, 0);
    endtask

    initial begin
        int d0;
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        frame_blank = 1'b0;
        pix_data = '0;
        pix_valid = 1'b0;
        #12;
        chk("reset_we", we, 0);
        chk("reset_busy", busy, 0);
        chk("reset_ready", pix_ready, 0);
        chk("reset_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        realign();

        // Full load with index data; abort during DONE must be ignored.
        d0 = n_done;
        run_load(100, 1'b1, 0, -1, -1, -1, 1'b0);
        finish_full("full", d0, 1'b1);

        // Held out of blanking for 10 cycles first.
        d0 = n_done;
        run_load(100, 1'b0, 10, -1, -1, -1, 1'b0);
        finish_full("wait_blank", d0, 1'b0);

        // Blanking drops after 100 transfers for 20 cycles.
        d0 = n_done;
        run_load(100, 1'b0, 0, 100, -1, -1, 1'b0);
        finish_full("pause", d0, 1'b0);

        // 50% valid gaps, stray start pulses while busy.
        d0 = n_done;
        run_load(50, 1'b1, 0, -1, -1, -1, 1'b1);
        finish_full("gaps", d0, 1'b0);

        // Abort after 70 transfers, then a clean restart from 0.
        d0 = n_done;
        run_load(100, 1'b0, 0, -1, 70, -1, 1'b0);
        repeat (3) realign();
        chk("abort_no_done", n_done - d0, 0);
        chk("abort_q_empty", exp_q.size(), 0);
        run_load(70, 1'b0, 0, -1, -1, -1, 1'b0);
        finish_full("restart", d0, 1'b0);

        // Start and abort together in IDLE: stay idle.
        start = 1'b1;
        abort = 1'b1;
        realign();
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort_idle", busy, 0);
        realign();
        chk("start_abort_idle2", busy, 0);

        // Reset after 2000 transfers, no done afterwards.
        d0 = n_done;
        run_load(100, 1'b0, 0, -1, -1, 2000, 1'b0);
        repeat (10) realign();
        chk("rst_no_done", n_done - d0, 0);
        chk("rst_idle", busy, 0);
        chk("rst_q_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sprite_loader.md
SPRITE_LOADER -- requirements
Module: sprite_loader

Interface
REQ-001 SHALL have parameter PIXEL_W, default 8, width of one sprite pixel word.
REQ-002 SHALL have parameter DIM_LOG2, default 6, log2 of sprite edge (64x64 sprite, 12-bit address).
REQ-003 SHALL have port clk  in  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous and active-low.
REQ-005 SHALL have port start  in  1  request to load one full sprite; sampled in IDLE only.
REQ-006 SHALL have port abort  in  1  cancel load in progress.
REQ-007 SHALL have port frame_blank  in  1  high while the display is not reading sprite memory (vertical blanking).
REQ-008 SHALL have port pix_data  in  PIXEL_W  incoming pixel, raster order (row-major, column fastest).
REQ-009 SHALL have port pix_valid  in  1  pix_data valid.
REQ-010 SHALL have port pix_ready  out  1  loader accepts pix_data this cycle.
REQ-011 SHALL have port we  out  1  sprite memory write enable.
REQ-012 SHALL have port waddr  out  2*DIM_LOG2  write address {row, col}, same layout as the display read address.
REQ-013 SHALL have port wdata  out  PIXEL_W  write data.
REQ-014 SHALL have port busy  out  1  high in any state other than IDLE.
REQ-015 SHALL have port done  out  1  one-cycle pulse after the last pixel is written.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT_BLANK, LOAD, DONE.
REQ-017 IDLE: start=1 and abort=0 -> WAIT_BLANK; col and row counters cleared to 0.
REQ-018 WAIT_BLANK: frame_blank=1 -> LOAD; otherwise stay.
REQ-019 LOAD: pix_ready SHALL equal frame_blank (combinational); no other state asserts pix_ready.
REQ-020 Transfer occurs when pix_valid and pix_ready are both 1 in the same cycle.
REQ-021 On transfer, the next cycle SHALL show we=1, waddr={row,col} of that pixel, wdata=pix_data (latency 1 cycle); otherwise we=0.
REQ-022 col SHALL increment per transfer and wrap from 2^DIM_LOG2-1 to 0, incrementing row on wrap.
REQ-023 Transfer at row=col=2^DIM_LOG2-1 SHALL move FSM to DONE; counters return to 0.
REQ-024 DONE: done=1 for exactly one cycle (coinciding with the final we pulse), then IDLE.
REQ-025 frame_blank falling during LOAD SHALL pause transfers (pix_ready=0) without losing counter state; resumes when frame_blank rises again.
REQ-026 abort=1 in WAIT_BLANK or LOAD SHALL return FSM to IDLE next cycle, with no done pulse; a transfer in the abort cycle is not accepted (pix_ready forced 0).
REQ-027 abort in DONE SHALL be ignored; done still pulses.
REQ-028 start while busy=1 SHALL be ignored; start and abort together in IDLE: abort wins, stay IDLE.
REQ-029 waddr and wdata SHALL hold their last values when we=0.

Reset
REQ-030 rst_n low SHALL immediately force IDLE, counters 0, we=0, waddr=0, wdata=0, busy=0, done=0, pix_ready=0.
REQ-031 Reset asserted mid-load SHALL discard the load; no done pulse after release.

Structure
REQ-032 Shared package sprite_pkg SHALL hold the FSM state enum and sprite-geometry constants (DIM_LOG2 default, address width), shared with the display-side address generator.
REQ-033 One sub-module, sprite_raster_counter (col/row counter with increment enable, clear, and last-pixel flag), is natural and SHALL be used.

Verification
REQ-034 Full load, frame_blank=1, pix_valid always 1, pix_data=index[7:0] -> 4096 writes, waddr 0..4095 in order, wdata=waddr[7:0], done pulses once in cycle of write 4095.
REQ-035 Start with frame_blank=0 for 10 cycles -> busy=1, pix_ready=0, no we until frame_blank rises.
REQ-036 frame_blank drops after 100 transfers for 20 cycles -> no writes in gap; next write waddr=100 (row 1, col 36).
REQ-037 Random pix_valid gaps (50%) -> write sequence identical to REQ-034, done once.
REQ-038 abort after 70 transfers -> IDLE next cycle, busy=0, no done; new start restarts at waddr=0.
REQ-039 rst_n low after 2000 transfers -> all outputs 0 asynchronously; no done after release.
